// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_div_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH      = 4;
  localparam int DW         = 2 * WIDTH;
  localparam int CNT_W      = $clog2(DW + 1);
  localparam logic [7:0] UIO_OE_VAL = 8'hF8;
endpackage

// File: rtl/seq_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module seq_div_step #(
  parameter int W = 4
) (
  input  logic [W:0]   i_rem,
  input  logic         i_bit,
  input  logic [W-1:0] i_divisor,
  output logic [W:0]   o_rem,
  output logic         o_qbit
);
  logic [W:0] w_shift;
  logic [W:0] w_div;
  logic       w_unused_msb;

  // The kept remainder is below the divisor, so its top bit never carries into the shift.
  assign w_unused_msb = i_rem[W];

  always_comb begin
    w_shift = {i_rem[W-1:0], i_bit};
    w_div   = {1'b0, i_divisor};
    if (w_shift >= w_div) begin
      o_rem  = w_shift - w_div;
      o_qbit = 1'b1;
    end else begin
      o_rem  = w_shift;
      o_qbit = 1'b0;
    end
  end
endmodule

// File: rtl/tt_um_seq_div.sv
// Sequential restoring divider, one quotient bit per clock.
// Optional build macro SEQ_DIV_ZERO_SHORTCUT_EN: a zero divisor skips the iterations.
module tt_um_seq_div
  import seq_div_pkg::*;
#(
  parameter int WIDTH = seq_div_pkg::WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2*WIDTH-1:0]   ui_in,
  input  logic [7:0]           uio_in,
  input  logic                 in_valid,
  output logic [2*WIDTH-1:0]   uo_out,
  output logic [7:0]           uio_out,
  output logic [7:0]           uio_oe,
  output logic                 busy,
  output logic                 out_done
);
  localparam int QW = 2 * WIDTH;
  localparam int CW = $clog2(QW + 1);

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [QW-1:0]      r_dividend;
  logic [QW-1:0]      r_quot;
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH:0]     r_rem;
  logic               r_dz;
  logic [QW-1:0]      r_uo_out;
  logic [7:0]         r_uio_out;
  logic               r_busy;
  logic               r_out_done;
  logic [WIDTH:0]     w_next_rem;
  logic               w_qbit;
  logic               w_unused;

  assign w_unused = ^uio_in[7:WIDTH];

  seq_div_step #(.W(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_dividend[QW-1]),
    .i_divisor (r_divisor),
    .o_rem     (w_next_rem),
    .o_qbit    (w_qbit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_dividend <= '0;
      r_quot     <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_dz       <= 1'b0;
      r_uo_out   <= '0;
      r_uio_out  <= 8'h00;
      r_busy     <= 1'b0;
      r_out_done <= 1'b0;
    end else begin
      r_out_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_dividend <= ui_in;
            r_divisor  <= uio_in[WIDTH-1:0];
            r_rem      <= '0;
            r_cnt      <= '0;
            r_quot     <= '0;
            r_dz       <= (uio_in[WIDTH-1:0] == '0);
            r_busy     <= 1'b1;
`ifdef SEQ_DIV_ZERO_SHORTCUT_EN
            // Same result the full iteration would produce for a zero divisor.
            if (uio_in[WIDTH-1:0] == '0) begin
              r_quot  <= '1;
              r_rem   <= {1'b0, ui_in[WIDTH-1:0]};
              r_state <= DONE;
            end else begin
              r_state <= RUN;
            end
`else
            r_state    <= RUN;
`endif
          end
        end
        RUN: begin
          r_rem      <= w_next_rem;
          r_quot     <= {r_quot[QW-2:0], w_qbit};
          r_dividend <= {r_dividend[QW-2:0], 1'b0};
          r_cnt      <= r_cnt + CW'(1);
          if (r_cnt == CW'(QW - 1)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_uo_out   <= r_quot;
          r_uio_out  <= {r_rem[WIDTH-1:0], r_dz, 3'b000};
          r_out_done <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign uo_out   = r_uo_out;
  assign uio_out  = r_uio_out;
  assign uio_oe   = UIO_OE_VAL;
  assign busy     = r_busy;
  assign out_done = r_out_done;
endmodule

// File: tb/tb_tt_um_seq_div.sv
// Scoreboard bench for tt_um_seq_div: stimulus pushes expectations, a monitor checks each out_done.
module tb_tt_um_seq_div;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
  logic       in_valid, busy, out_done;

`ifdef SEQ_DIV_ZERO_SHORTCUT_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 9;
`endif

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
    int         t_acc;
    int         lat;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   edges = 0;
  int   n_results = 0;
  int   n_issued = 0;
  logic prev_done = 1'b0;

  tt_um_seq_div dut (
    .clk(clk), .reset(reset), .ui_in(ui_in), .uio_in(uio_in), .in_valid(in_valid),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe), .busy(busy), .out_done(out_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every result pulse is matched against the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (out_done === 1'b1) begin
      chk("done_single_pulse", prev_done, 1'b0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: out_done with nothing pending, q=%0d", uo_out);
      end else begin
        e = sb.pop_front();
        n_results++;
        chk({e.name, ".quot"}, uo_out, e.q);
        chk({e.name, ".rem"}, uio_out[7:4], e.r);
        chk({e.name, ".div_zero"}, uio_out[3], e.dz);
        chk({e.name, ".low_bits"}, uio_out[2:0], 3'b000);
        chk({e.name, ".busy_low"}, busy, 1'b0);
        chk({e.name, ".latency"}, edges - e.t_acc, e.lat);
        chk({e.name, ".uio_oe"}, uio_oe, 8'hF8);
      end
    end
    prev_done <= out_done;
  end

  task automatic issue(input string nm, input int a, input int b,
                       input int q, input int r, input bit dz, input int lat);
    int   k = 0;
    exp_t e;
    while (busy !== 1'b0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk("idle_timeout", busy, 1'b0);
    ui_in    = a[7:0];
    uio_in   = {4'($urandom_range(15)), b[3:0]};
    in_valid = 1'b1;
    e.q = q[7:0]; e.r = r[3:0]; e.dz = dz; e.t_acc = edges + 1; e.lat = lat; e.name = nm;
    sb.push_back(e);
    n_issued++;
    @(negedge clk);
    in_valid = 1'b0;
    ui_in    = 8'($urandom);
    uio_in   = 8'($urandom);
    chk({nm, ".busy_high"}, busy, 1'b1);
  endtask

  task automatic drain();
    int k = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("drain_timeout", sb.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset.uo_out", uo_out, 8'h00);
    chk("reset.uio_out", uio_out, 8'h00);
    chk("reset.busy", busy, 1'b0);
    chk("reset.out_done", out_done, 1'b0);
    chk("reset.uio_oe", uio_oe, 8'hF8);
    reset = 1'b1;
    @(negedge clk);

    issue("200/7", 200, 7, 28, 4, 1'b0, 9);
    issue("255/15", 255, 15, 17, 0, 1'b0, 9);
    issue("255/1", 255, 1, 255, 0, 1'b0, 9);
    issue("0/5", 0, 5, 0, 0, 1'b0, 9);
    issue("6/9", 6, 9, 0, 6, 1'b0, 9);
    issue("100/0", 100, 0, 255, 4, 1'b1, ZLAT);
    drain();

    // Back-to-back with stray in_valid pulses while busy.
    issue("b2b_200/7", 200, 7, 28, 4, 1'b0, 9);
    repeat (3) begin
      ui_in = 8'd1; uio_in = 8'd1; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
    end
    issue("b2b_99/10", 99, 10, 9, 9, 1'b0, 9);
    drain();
    chk("result_count_b2b", n_results, n_issued);

    // Reset in the middle of an operation.
    issue("abort_200/7", 200, 7, 28, 4, 1'b0, 9);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort.uo_out", uo_out, 8'h00);
    chk("abort.uio_out", uio_out, 8'h00);
    chk("abort.busy", busy, 1'b0);
    chk("abort.out_done", out_done, 1'b0);
    sb.delete();
    n_issued--;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    issue("50/5", 50, 5, 10, 0, 1'b0, 9);
    drain();

    // Exhaustive sweep of nonzero divisors against a reference model.
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        issue($sformatf("sweep_%0d/%0d", a, b), a, b, a / b, a % b, 1'b0, 9);
      end
    end
    drain();
    chk("final_result_count", n_results, n_issued);
    chk("final_queue_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
